// File: rtl/sr_gen_pkg.sv
// Shared definitions for the set/reset pulse generator: default debounce
// parameters, synchroniser depth and the per-channel status record.
package sr_gen_pkg;

   localparam int DEB_CYCLES_DEF = 4;
   localparam int CNT_W_DEF      = 8;
   localparam int SYNC_STAGES    = 2;

   // Debounced level plus a combinational "level rises at this edge" flag.
   typedef struct packed {
      logic lvl;
      logic rise;
   } chan_status_t;

endpackage

// File: rtl/sr_pulse_gen_deb_chan.sv
// One button channel: two-flop synchroniser, debounce counter and
// rising-edge detect of the accepted (stable) level.
module deb_chan
   import sr_gen_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         btn,
   output chan_status_t status
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   sync_out;

   assign sync_out = sync_q[SYNC_STAGES-1];

   // Next-state: shift synchroniser, count disagreement, accept after DEB_CYCLES edges.
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], btn};
      stable_d = stable_q;
      cnt_d    = cnt_q;
      if (sync_out == stable_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         stable_d = sync_out;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State registers; reset drops any partial count and the synchroniser contents.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   // Rise is combinational so the parent can register its pulse on the same edge.
   always_comb begin
      status.lvl  = stable_q;
      status.rise = stable_d & ~stable_q;
   end

endmodule

// File: rtl/sr_pulse_gen.sv
// Set/reset pulse generator: debounces two raw buttons and issues clean,
// mutually exclusive single-cycle s/r pulses on debounced presses.
// Optional feature macro SRGEN_CONFLICT_CNT_EN adds an 8-bit saturating
// conflict event counter on port conflict_cnt.
module sr_pulse_gen
   import sr_gen_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       set_btn,
   input  logic       rst_btn,
   output logic       s,
   output logic       r,
   output logic       set_lvl,
   output logic       rst_lvl,
`ifdef SRGEN_CONFLICT_CNT_EN
   output logic [7:0] conflict_cnt,
`endif
   output logic       conflict
);

   chan_status_t set_st, rst_st;
   logic         s_q, s_d;
   logic         r_q, r_d;
   logic         conflict_q, conflict_d;

   deb_chan #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_set_chan (
      .clk    (clk),
      .rst    (rst),
      .btn    (set_btn),
      .status (set_st)
   );

   deb_chan #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_rst_chan (
      .clk    (clk),
      .rst    (rst),
      .btn    (rst_btn),
      .status (rst_st)
   );

   // Arbitration: simultaneous rises suppress both pulses and raise conflict.
   always_comb begin
      s_d        = set_st.rise & ~rst_st.rise;
      r_d        = rst_st.rise & ~set_st.rise;
      conflict_d = set_st.rise & rst_st.rise;
   end

   // Registered pulse outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         s_q        <= s_d;
         r_q        <= r_d;
         conflict_q <= conflict_d;
      end
   end

   assign s        = s_q;
   assign r        = r_q;
   assign conflict = conflict_q;
   assign set_lvl  = set_st.lvl;
   assign rst_lvl  = rst_st.lvl;

`ifdef SRGEN_CONFLICT_CNT_EN
   logic [7:0] ccnt_q, ccnt_d;

   // Saturating conflict count, advanced on the same edge that raises conflict.
   always_comb begin
      ccnt_d = ccnt_q;
      if (conflict_d && (ccnt_q != 8'hFF)) begin
         ccnt_d = ccnt_q + 8'd1;
      end
   end

   // Conflict counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         ccnt_q <= 8'd0;
      end else begin
         ccnt_q <= ccnt_d;
      end
   end

   assign conflict_cnt = ccnt_q;
`endif

endmodule

// File: tb/tb_sr_pulse_gen.sv
// Self-checking bench for sr_pulse_gen with a window-based reference model.
module tb_sr_pulse_gen;

   localparam int DEB = 4;

   logic clk = 1'b0;
   logic rst, set_btn, rst_btn;
   logic s, r, set_lvl, rst_lvl, conflict;
`ifdef SRGEN_CONFLICT_CNT_EN
   logic [7:0] conflict_cnt;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model state. hist[c] holds the button value sampled at the two
   // previous edges (oldest first); win[c] holds the synchronised values seen
   // at the last DEB edges since reset.
   bit hist [2][$];
   bit win  [2][$];
   bit st   [2];
   bit exp_s, exp_r, exp_conf;
   int exp_cnt;

   sr_pulse_gen #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .set_btn      (set_btn),
      .rst_btn      (rst_btn),
      .s            (s),
      .r            (r),
      .set_lvl      (set_lvl),
      .rst_lvl      (rst_lvl),
`ifdef SRGEN_CONFLICT_CNT_EN
      .conflict_cnt (conflict_cnt),
`endif
      .conflict     (conflict)
   );

   always #5 clk = ~clk;

   // A debounced level flips once the synchronised input has disagreed with
   // it for DEB consecutive edges.
   task automatic model_edge(input bit rs, input bit sb, input bit rb);
      bit btn [2];
      bit rise [2];
      btn[0] = sb;
      btn[1] = rb;
      for (int c = 0; c < 2; c++) begin
         rise[c] = 1'b0;
         if (rs) begin
            hist[c] = {1'b0, 1'b0};
            win[c].delete();
            st[c] = 1'b0;
         end else begin
            win[c].push_back(hist[c][0]);
            if (win[c].size() > DEB) void'(win[c].pop_front());
            if (win[c].size() == DEB) begin
               bit all_diff;
               all_diff = 1'b1;
               foreach (win[c][i]) if (win[c][i] == st[c]) all_diff = 1'b0;
               if (all_diff) begin
                  rise[c] = ~st[c];
                  st[c]   = ~st[c];
               end
            end
            void'(hist[c].pop_front());
            hist[c].push_back(btn[c]);
         end
      end
      if (rs) begin
         exp_s = 0; exp_r = 0; exp_conf = 0; exp_cnt = 0;
      end else begin
         exp_s    = rise[0] & ~rise[1];
         exp_r    = rise[1] & ~rise[0];
         exp_conf = rise[0] & rise[1];
         if (exp_conf && exp_cnt < 255) exp_cnt++;
      end
   endtask

   // Drive one cycle of inputs, clock it, advance the model, settle past the edge.
   task automatic tick(input bit rs, input bit sb, input bit rb);
      rst = rs; set_btn = sb; rst_btn = rb;
      @(posedge clk);
      model_edge(rs, sb, rb);
      #1;
   endtask

   task automatic test_reset();
      tick(1, 1, 1);
      tick(1, 1, 1);
      checks++;
      if ({s, r, conflict, set_lvl, rst_lvl} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs: got s=%b r=%b conflict=%b set_lvl=%b rst_lvl=%b, want all 0",
                  s, r, conflict, set_lvl, rst_lvl);
      end
`ifdef SRGEN_CONFLICT_CNT_EN
      checks++;
      if (conflict_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d want 0", conflict_cnt);
      end
`endif
   endtask

   task automatic test_set_latency();
      for (int e = 1; e <= 8; e++) begin
         tick(0, 1, 0);
         checks++;
         if (s !== (e == 6) || set_lvl !== (e >= 6) || r !== 1'b0 || conflict !== 1'b0) begin
            errors++;
            $display("FAIL set_latency edge %0d: got s=%b set_lvl=%b r=%b conflict=%b, want s=%b set_lvl=%b r=0 conflict=0",
                     e, s, set_lvl, r, conflict, (e == 6), (e >= 6));
         end
      end
      for (int e = 1; e <= 10; e++) begin
         tick(0, 0, 0);
         checks++;
         if (s !== 1'b0 || set_lvl !== st[0]) begin
            errors++;
            $display("FAIL set_release edge %0d: got s=%b set_lvl=%b, want s=0 set_lvl=%b", e, s, set_lvl, st[0]);
         end
      end
   endtask

   task automatic test_bounce();
      bit pat [4] = '{1, 0, 1, 0};
      for (int i = 0; i < 4; i++) begin
         tick(0, pat[i], 0);
         checks++;
         if (s !== 1'b0) begin
            errors++;
            $display("FAIL bounce_no_pulse step %0d: got s=%b want 0", i, s);
         end
      end
      for (int e = 1; e <= 9; e++) begin
         tick(0, 1, 0);
         checks++;
         if (s !== (e == 6) || set_lvl !== (e >= 6)) begin
            errors++;
            $display("FAIL bounce_steady edge %0d: got s=%b set_lvl=%b, want s=%b set_lvl=%b",
                     e, s, set_lvl, (e == 6), (e >= 6));
         end
      end
      for (int e = 0; e < 10; e++) tick(0, 0, 0);
   endtask

   task automatic test_hold_release();
      int pulses;
      pulses = 0;
      for (int e = 1; e <= 50; e++) begin
         tick(0, 0, 1);
         if (r) pulses++;
         if (e == 6) begin
            checks++;
            if (r !== 1'b1 || rst_lvl !== 1'b1) begin
               errors++;
               $display("FAIL hold_r_pulse: got r=%b rst_lvl=%b want 1 1", r, rst_lvl);
            end
         end
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL hold_single_pulse: got %0d pulses want 1", pulses);
      end
      pulses = 0;
      for (int e = 1; e <= 10; e++) begin
         tick(0, 0, 0);
         if (r) pulses++;
         checks++;
         if (rst_lvl !== (e < 6)) begin
            errors++;
            $display("FAIL release_level edge %0d: got rst_lvl=%b want %b", e, rst_lvl, (e < 6));
         end
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL release_no_pulse: got %0d pulses want 0", pulses);
      end
      pulses = 0;
      for (int e = 1; e <= 12; e++) begin
         tick(0, 0, 1);
         if (r) pulses++;
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL repress_pulse: got %0d pulses want 1", pulses);
      end
      for (int e = 0; e < 10; e++) tick(0, 0, 0);
   endtask

   task automatic test_conflict();
      int nconf;
      nconf = 0;
      tick(1, 0, 0);
      tick(1, 0, 0);
      for (int it = 0; it < 300; it++) begin
         for (int e = 1; e <= 8; e++) begin
            tick(0, 1, 1);
            if (conflict) nconf++;
            if (it == 0 && e == 6) begin
               checks++;
               if (conflict !== 1'b1 || s !== 1'b0 || r !== 1'b0) begin
                  errors++;
                  $display("FAIL conflict_first: got conflict=%b s=%b r=%b want 1 0 0", conflict, s, r);
               end
`ifdef SRGEN_CONFLICT_CNT_EN
               checks++;
               if (conflict_cnt !== 8'd1) begin
                  errors++;
                  $display("FAIL conflict_cnt_first: got %0d want 1", conflict_cnt);
               end
`endif
            end
            if (s || r) begin
               checks++;
               errors++;
               $display("FAIL conflict_pulse iter %0d edge %0d: got s=%b r=%b want 0 0", it, e, s, r);
            end
         end
         for (int e = 1; e <= 8; e++) tick(0, 0, 0);
      end
      checks++;
      if (nconf != 300) begin
         errors++;
         $display("FAIL conflict_total: got %0d want 300", nconf);
      end
`ifdef SRGEN_CONFLICT_CNT_EN
      checks++;
      if (conflict_cnt !== 8'd255) begin
         errors++;
         $display("FAIL conflict_cnt_sat: got %0d want 255", conflict_cnt);
      end
`endif
   endtask

   task automatic test_reset_mid();
      tick(1, 0, 0);
      tick(1, 0, 0);
      for (int e = 1; e <= 3; e++) tick(0, 1, 0);
      tick(1, 1, 0);
      for (int e = 1; e <= 9; e++) begin
         tick(0, 1, 0);
         checks++;
         if (s !== (e == 6) || set_lvl !== (e >= 6)) begin
            errors++;
            $display("FAIL reset_mid edge %0d: got s=%b set_lvl=%b, want s=%b set_lvl=%b",
                     e, s, set_lvl, (e == 6), (e >= 6));
         end
      end
   endtask

   task automatic test_random();
      bit sb, rb, rs, prev_s, prev_r;
      tick(1, 0, 0);
      sb = 0; rb = 0; prev_s = 0; prev_r = 0;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(7) == 0) sb = ~sb;
         if ($urandom_range(7) == 0) rb = ~rb;
         rs = ($urandom_range(1999) == 0);
         tick(rs, sb, rb);
         checks++;
         if (s !== exp_s || r !== exp_r || conflict !== exp_conf ||
             set_lvl !== st[0] || rst_lvl !== st[1]) begin
            errors++;
            $display("FAIL random cyc %0d: got s=%b r=%b c=%b sl=%b rl=%b, want s=%b r=%b c=%b sl=%b rl=%b",
                     i, s, r, conflict, set_lvl, rst_lvl, exp_s, exp_r, exp_conf, st[0], st[1]);
         end
         checks++;
         if ((s & r) !== 1'b0 || (s & prev_s) || (r & prev_r)) begin
            errors++;
            $display("FAIL random_exclusive cyc %0d: got s=%b r=%b prev_s=%b prev_r=%b", i, s, r, prev_s, prev_r);
         end
`ifdef SRGEN_CONFLICT_CNT_EN
         checks++;
         if (conflict_cnt !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL random_cnt cyc %0d: got %0d want %0d", i, conflict_cnt, exp_cnt);
         end
`endif
         prev_s = s;
         prev_r = r;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int c = 0; c < 2; c++) begin
         hist[c] = {1'b0, 1'b0};
         st[c] = 1'b0;
      end
      exp_cnt = 0;
      rst = 1; set_btn = 0; rst_btn = 0;
      #2;
      test_reset();
      test_set_latency();
      test_bounce();
      test_hold_release();
      test_conflict();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
